// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and constants for the cache bus arbiter.
//   state_e  : arbiter sequencing states (IDLE=0, ISSUE=1, RESP=2)
//   region_e : data-port address map classes
//   DEF_*    : default Cache index width and MMIO register byte addresses
package cache_bus_arbiter_pkg;

    localparam int unsigned DEF_IDX_W    = 11;
    localparam logic [63:0] DEF_ART_BASE = 64'h0000_0000_2000_0000;
    localparam logic [63:0] DEF_KEY_BASE = 64'h0000_0000_2000_0004;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RegCache    = 2'd0,
        RegUart     = 2'd1,
        RegKey      = 2'd2,
        RegUnmapped = 2'd3
    } region_e;

endpackage

// File: rtl/cache_bus_arbiter_bus_addr_decode.sv
// Combinational data-port address decoder.
//   addr      : 64-bit byte address
//   region    : UART > keyboard > Cache > unmapped, in that priority
//   cache_hit : raw Cache range test, used alone by the fetch port
//   idx       : Cache word index, addr[1:0] dropped
module cache_bus_arbiter_bus_addr_decode
    import cache_bus_arbiter_pkg::*;
#(
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter logic [63:0] ART_BASE = DEF_ART_BASE,
    parameter logic [63:0] KEY_BASE = DEF_KEY_BASE
) (
    input  logic [63:0]      addr,
    output region_e          region,
    output logic             cache_hit,
    output logic [IDX_W-1:0] idx
);

    localparam logic [63:0] CACHE_LIMIT = 64'd1 << (IDX_W + 2);

    always_comb begin
        cache_hit = addr < CACHE_LIMIT;
        idx       = addr[IDX_W+1:2];
        if (addr == ART_BASE) begin
            region = RegUart;
        end else if (addr == KEY_BASE) begin
            region = RegKey;
        end else if (cache_hit) begin
            region = RegCache;
        end else begin
            region = RegUnmapped;
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Single-port Cache BRAM arbiter shared by the instruction-fetch and data ports,
// with JTAG UART (write strobe) and PS/2 keyboard (read) decoding on the data port.
//   CLOCK_50, KEY0        : clock, async active-low reset
//   if_*                  : fetch port (req/addr in, gnt/rvalid/rdata out)
//   d_*                   : data port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*                 : BRAM port, read data one cycle after mem_en
//   uart_write_n/_wdata   : UART write strobe and data
//   key_code/key_ack      : keyboard code in, read acknowledge out
//   bus_err               : pulse on an unmapped access
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter logic [63:0] ART_BASE = DEF_ART_BASE,
    parameter logic [63:0] KEY_BASE = DEF_KEY_BASE
) (
    input  logic             CLOCK_50,
    input  logic             KEY0,
    input  logic             if_req,
    input  logic [63:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [63:0]      d_addr,
    input  logic [63:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [63:0]      d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             uart_write_n,
    output logic [31:0]      uart_wdata,
    input  logic [7:0]       key_code,
    output logic             key_ack,
    output logic             bus_err
);

    state_e      state_q, state_d;
    logic        sel_d_q, sel_d_d;     // 1: data port owns the transaction
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_d_q, last_d_d;   // 1: data port was served last
    logic        d_block_q, d_block_d;

    logic             d_elig, pick_d;
    region_e          region, eff_region;
    logic             cache_hit;
    logic [IDX_W-1:0] idx;
    logic             issue, resp;
    logic [31:0]      rd_word;

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^d_wdata[63:32];

    cache_bus_arbiter_bus_addr_decode #(
        .IDX_W    (IDX_W),
        .ART_BASE (ART_BASE),
        .KEY_BASE (KEY_BASE)
    ) u_bus_addr_decode (
        .addr      (addr_q),
        .region    (region),
        .cache_hit (cache_hit),
        .idx       (idx)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= StIdle;
            sel_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_d_q  <= 1'b1;
            d_block_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_d_q   <= sel_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_d_q  <= last_d_d;
            d_block_q <= d_block_d;
        end
    end

    // A data write is not re-accepted while its d_req stays high after the
    // grant, so a held request cannot repeat an MMIO side effect. Reads (and
    // fetches) re-arm immediately so held requests stream.
    assign d_elig = d_req && !d_block_q;
    assign pick_d = d_elig && (!if_req || !last_d_q);

    always_comb begin
        state_d   = state_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_d_d  = last_d_q;
        d_block_d = d_block_q && d_req;
        unique case (state_q)
            StIdle: begin
                if (if_req || d_elig) begin
                    sel_d_d  = pick_d;
                    we_d     = pick_d && d_we;
                    addr_d   = pick_d ? d_addr : if_addr;
                    wdata_d  = d_wdata[31:0];
                    last_d_d = pick_d;
                    state_d  = StIssue;
                    if (pick_d && d_we) begin
                        d_block_d = 1'b1;
                    end
                end
            end
            StIssue: state_d = we_q ? StIdle : StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue = (state_q == StIssue);
        resp  = (state_q == StResp);

        // The fetch port only sees the Cache; MMIO addresses are unmapped for it.
        if (sel_d_q) begin
            eff_region = region;
        end else begin
            eff_region = cache_hit ? RegCache : RegUnmapped;
        end

        if_gnt       = issue && !sel_d_q;
        d_gnt        = issue && sel_d_q;
        mem_en       = issue && (eff_region == RegCache);
        mem_we       = mem_en && we_q;
        mem_addr     = mem_en ? idx : '0;
        mem_wdata    = mem_we ? wdata_q : '0;
        uart_write_n = !(issue && (eff_region == RegUart) && we_q);
        uart_wdata   = uart_write_n ? '0 : wdata_q;
        key_ack      = issue && (eff_region == RegKey) && !we_q;
        bus_err      = issue && (eff_region == RegUnmapped);

        unique case (eff_region)
            RegCache: rd_word = mem_rdata;
            RegKey:   rd_word = {24'd0, key_code};
            default:  rd_word = '0;
        endcase

        if_rvalid = resp && !sel_d_q;
        d_rvalid  = resp && sel_d_q;
        if_rdata  = if_rvalid ? rd_word : '0;
        d_rdata   = d_rvalid ? {32'd0, rd_word} : '0;
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    localparam int unsigned IDX_W = 11;

    logic             CLOCK_50 = 1'b0;
    logic             KEY0 = 1'b0;
    logic             if_req = 1'b0;
    logic [63:0]      if_addr = '0;
    logic             if_gnt, if_rvalid;
    logic [31:0]      if_rdata;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [63:0]      d_addr = '0;
    logic [63:0]      d_wdata = '0;
    logic             d_gnt, d_rvalid;
    logic [63:0]      d_rdata;
    logic             mem_en, mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = '0;
    logic             uart_write_n;
    logic [31:0]      uart_wdata;
    logic [7:0]       key_code = '0;
    logic             key_ack, bus_err;

    cache_bus_arbiter #(
        .IDX_W    (IDX_W),
        .ART_BASE (DEF_ART_BASE),
        .KEY_BASE (DEF_KEY_BASE)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .KEY0         (KEY0),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .uart_write_n (uart_write_n),
        .uart_wdata   (uart_wdata),
        .key_code     (key_code),
        .key_ack      (key_ack),
        .bus_err      (bus_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // BRAM model: registered read, write-first not needed here
    logic [31:0] bram [0:2047];
    always @(posedge CLOCK_50) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            mem_rdata <= bram[mem_addr];
        end
    end

    typedef struct {
        bit          is_d;
        bit          is_resp;
        bit          mem_en;
        bit          mem_we;
        logic [10:0] mem_addr;
        logic [31:0] mem_wdata;
        bit          uart;
        logic [31:0] uart_wdata;
        bit          key_ack;
        bit          bus_err;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   stray = 0;
    int   uart_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk_gnt(bit is_d, bit en, bit we, logic [10:0] a, logic [31:0] wd,
                                    bit uart, logic [31:0] uwd, bit key, bit err);
        exp_t e;
        e.is_d = is_d; e.is_resp = 1'b0; e.mem_en = en; e.mem_we = we; e.mem_addr = a;
        e.mem_wdata = wd; e.uart = uart; e.uart_wdata = uwd; e.key_ack = key;
        e.bus_err = err; e.rdata = '0;
        return e;
    endfunction

    function automatic exp_t mk_resp(bit is_d, logic [63:0] rd);
        exp_t e;
        e = mk_gnt(is_d, 0, 0, '0, '0, 0, '0, 0, 0);
        e.is_resp = 1'b1;
        e.rdata = rd;
        return e;
    endfunction

    // Monitor: pops one expectation per grant/rvalid pulse.
    exp_t m;
    always @(negedge CLOCK_50) begin
        if (if_gnt || d_gnt || if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_event: gnt=%b/%b rvalid=%b/%b with empty queue at %0t",
                         if_gnt, d_gnt, if_rvalid, d_rvalid, $time);
            end else begin
                m = sb.pop_front();
                chk("port", {63'd0, d_gnt | d_rvalid}, {63'd0, m.is_d});
                chk("phase", {63'd0, if_rvalid | d_rvalid}, {63'd0, m.is_resp});
                if (!m.is_resp) begin
                    chk("mem_en", {63'd0, mem_en}, {63'd0, m.mem_en});
                    chk("mem_we", {63'd0, mem_we}, {63'd0, m.mem_we});
                    chk("mem_addr", {53'd0, mem_addr}, {53'd0, m.mem_addr});
                    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m.mem_wdata});
                    chk("uart_strobe", {63'd0, !uart_write_n}, {63'd0, m.uart});
                    chk("uart_wdata", {32'd0, uart_wdata}, {32'd0, m.uart_wdata});
                    chk("key_ack", {63'd0, key_ack}, {63'd0, m.key_ack});
                    chk("bus_err", {63'd0, bus_err}, {63'd0, m.bus_err});
                end else begin
                    chk("rdata", m.is_d ? d_rdata : {32'd0, if_rdata}, m.rdata);
                end
            end
        end else if (mem_en || mem_we || !uart_write_n || key_ack || bus_err) begin
            stray++;
        end
        if (!uart_write_n) uart_low++;
    end

    task automatic wait_gnt(input bit is_d, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLOCK_50);
            if (is_d ? d_gnt : if_gnt) seen = 1'b1;
        end
        chk(is_d ? "d_gnt_wait" : "if_gnt_wait", {63'd0, seen}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLOCK_50);
        chk("queue_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge CLOCK_50);
    endtask

    task automatic d_txn(input bit we, input logic [63:0] a, input logic [63:0] wd);
        @(posedge CLOCK_50); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_gnt(1'b1, 20);
        @(posedge CLOCK_50); #1;
        d_req = 1'b0;
    endtask

    task automatic f_txn(input logic [63:0] a);
        @(posedge CLOCK_50); #1;
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b0, 20);
        @(posedge CLOCK_50); #1;
        if_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, {56'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we,
                                key_ack, bus_err}, 64'd0);
        chk({tag, "_uart_write_n"}, {63'd0, uart_write_n}, 64'd1);
        chk({tag, "_data"}, {32'd0, mem_wdata} | {32'd0, uart_wdata} | {32'd0, if_rdata} |
                            d_rdata | {53'd0, mem_addr}, 64'd0);
        chk({tag, "_state"}, {62'd0, dut.state_q}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) bram[i] = 32'd0;
        bram[0]    = 32'h1111_1111;
        bram[1]    = 32'h3333_3333;
        bram[2]    = 32'h2222_2222;
        bram[4]    = 32'hDEAD_BEEF;
        bram[2047] = 32'h5A5A_5A5A;

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_reset_outputs("reset");
        KEY0 = 1'b1;

        // Tie straight after reset: fetch first, then alternate.
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk_gnt(0, 1, 0, 11'd0, '0, 0, '0, 0, 0));
            sb.push_back(mk_resp(0, 64'h1111_1111));
            sb.push_back(mk_gnt(1, 1, 0, 11'd2, '0, 0, '0, 0, 0));
            sb.push_back(mk_resp(1, 64'h2222_2222));
        end
        @(posedge CLOCK_50); #1;
        if_req = 1'b1; if_addr = 64'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8;
        begin
            int g = 0;
            for (int i = 0; i < 40 && g < 4; i++) begin
                @(negedge CLOCK_50);
                if (if_gnt || d_gnt) g++;
            end
            chk("rr_grants", 64'(g), 64'd4);
        end
        @(posedge CLOCK_50); #1;
        if_req = 1'b0; d_req = 1'b0;
        drain();

        // Plain BRAM read.
        sb.push_back(mk_gnt(1, 1, 0, 11'd4, '0, 0, '0, 0, 0));
        sb.push_back(mk_resp(1, 64'h0000_0000_DEAD_BEEF));
        d_txn(1'b0, 64'h10, 64'h0);
        drain();

        // UART write with d_req held 5 cycles: single strobe, no BRAM access.
        sb.push_back(mk_gnt(1, 0, 0, '0, '0, 1, 32'h41, 0, 0));
        @(posedge CLOCK_50); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = DEF_ART_BASE; d_wdata = 64'h41;
        repeat (5) @(posedge CLOCK_50);
        #1;
        d_req = 1'b0;
        drain();

        // Keyboard read.
        key_code = 8'h61;
        sb.push_back(mk_gnt(1, 0, 0, '0, '0, 0, '0, 1, 0));
        sb.push_back(mk_resp(1, 64'h61));
        d_txn(1'b0, DEF_KEY_BASE, 64'h0);
        drain();

        // Unmapped data read.
        sb.push_back(mk_gnt(1, 0, 0, '0, '0, 0, '0, 0, 1));
        sb.push_back(mk_resp(1, 64'h0));
        d_txn(1'b0, 64'h1_0000, 64'h0);
        drain();

        // BRAM write (upper data bits ignored) then read back.
        sb.push_back(mk_gnt(1, 1, 1, 11'd8, 32'hCAFE_F00D, 0, '0, 0, 0));
        d_txn(1'b1, 64'h20, 64'hFFFF_FFFF_CAFE_F00D);
        drain();
        sb.push_back(mk_gnt(1, 1, 0, 11'd8, '0, 0, '0, 0, 0));
        sb.push_back(mk_resp(1, 64'hCAFE_F00D));
        d_txn(1'b0, 64'h20, 64'h0);
        drain();

        // Last Cache word, low address bits ignored.
        sb.push_back(mk_gnt(1, 1, 0, 11'd2047, '0, 0, '0, 0, 0));
        sb.push_back(mk_resp(1, 64'h5A5A_5A5A));
        d_txn(1'b0, 64'h1FFF, 64'h0);
        drain();

        // Fetch just past the Cache: error and zero data.
        sb.push_back(mk_gnt(0, 0, 0, '0, '0, 0, '0, 0, 1));
        sb.push_back(mk_resp(0, 64'h0));
        f_txn(64'h2000);
        drain();

        // Reset during RESP of a fetch: no rvalid may follow.
        sb.push_back(mk_gnt(0, 1, 0, 11'd1, '0, 0, '0, 0, 0));
        @(posedge CLOCK_50); #1;
        if_req = 1'b1; if_addr = 64'h4;
        wait_gnt(1'b0, 20);
        @(posedge CLOCK_50); #1;
        KEY0 = 1'b0; if_req = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge CLOCK_50); #1;
        KEY0 = 1'b1;
        #1;
        chk("post_reset_state", {62'd0, dut.state_q}, 64'd0);
        repeat (4) @(posedge CLOCK_50);
        chk("post_reset_queue", 64'(sb.size()), 64'd0);

        // Normal operation resumes.
        sb.push_back(mk_gnt(1, 1, 0, 11'd4, '0, 0, '0, 0, 0));
        sb.push_back(mk_resp(1, 64'h0000_0000_DEAD_BEEF));
        d_txn(1'b0, 64'h10, 64'h0);
        drain();

        chk("stray_strobes", 64'(stray), 64'd0);
        chk("uart_low_cycles", 64'(uart_low), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
